ts_gbe_framer: RTL and testbench



---
 rtl/ts_gbe_framer.sv | 207 ++++++++++++++++++++
 tb/tb_ts_gbe_framer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_gbe_framer.sv
// ts_gbe_framer
//   Captures routed TS packet bursts from the TS/EMM mixer into a two-slot
//   ping-pong store and replays each committed packet as a byte stream with
//   SOP/EOP, GbE port select and a ready/valid handshake.
//
//   Burst layout: word0 = {gbe[1:0], 14'b0, udp_port[15:0]}, word1 = dest_ip,
//   words 2..PKT_WORDS-1 = TS bytes (MSB first).
//   Output packet: ip[31:24..7:0], port[15:8], port[7:0], then TS bytes.
//
// Ports
//   clk, rst       clock, synchronous active-low reset
//   din, din_en    burst words from the mixer; contiguous din_en = one burst
//   out_data/en    output byte and its valid
//   out_sop/eop    first/last byte markers, qualified by out_en
//   out_gbe        target GbE port, constant over a packet
//   out_rdy        downstream accept (out_en & out_rdy)
//   err_cnt        saturating count of rejected bursts
//   drop_cnt       saturating count of bursts dropped for lack of a free slot
//
// Build option
//   TS_SYNC_CHECK_EN : when defined, word2[31:24] must equal 8'h47 to commit.

module ts_gbe_framer #(
  parameter int PKT_WORDS  = 49,
  parameter int IFG_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      din,
  input  logic             din_en,
  output logic [7:0]       out_data,
  output logic             out_en,
  output logic             out_sop,
  output logic             out_eop,
  output logic [1:0]       out_gbe,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PKT_BYTES = 6 + (PKT_WORDS - 2) * 4;
  localparam logic [7:0] GAP_LAST = (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_GAP} state_t;

  logic [31:0] r_mem [2][PKT_WORDS];
  logic [1:0]  r_full;
  logic        r_oldest;
  logic        r_rd_slot;
  logic        r_in_burst;
  logic        r_cap_act;
  logic        r_wr_slot;
  logic [5:0]  r_wr_cnt;
  state_t      r_state;
  logic [7:0]  r_byte;
  logic [7:0]  r_gap_cnt;

  logic        w_burst_start, w_burst_end, w_slot_avail, w_new_slot;
  logic        w_wr_slot, w_wr_en, w_sync_ok, w_len_ok, w_commit, w_reject;
  logic [5:0]  w_wr_idx;
  logic        w_accept, w_release, w_other_busy, w_start, w_slot;
  logic [7:0]  w_idx, w_off, w_byte;
  logic [5:0]  w_word_idx;
  logic [1:0]  w_lane;
  logic [31:0] w_word;

  // ---------------- input capture ----------------
  assign w_burst_start = din_en & ~r_in_burst;
  assign w_burst_end   = ~din_en & r_in_burst;
  assign w_slot_avail  = ~&r_full;
  assign w_new_slot    = r_full[0];          // slot 0 preferred when free
  assign w_wr_slot     = w_burst_start ? w_new_slot : r_wr_slot;
  assign w_wr_idx      = w_burst_start ? 6'd0 : r_wr_cnt;
  assign w_wr_en       = din_en & (w_burst_start ? w_slot_avail : r_cap_act)
                         & (w_wr_idx < 6'(PKT_WORDS));

`ifdef TS_SYNC_CHECK_EN
  assign w_sync_ok = (r_mem[r_wr_slot][2][31:24] == 8'h47);
`else
  assign w_sync_ok = 1'b1;
`endif

  assign w_len_ok = (r_wr_cnt == 6'(PKT_WORDS));
  assign w_commit = w_burst_end & r_cap_act & w_len_ok & w_sync_ok;
  assign w_reject = w_burst_end & r_cap_act & ~(w_len_ok & w_sync_ok);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_slot][w_wr_idx] <= din;
  end

  // ---------------- output byte selection ----------------
  assign w_accept  = out_en & out_rdy;
  assign w_release = w_accept & (r_byte == 8'(PKT_BYTES - 1));
  // The other slot still holds an older packet unless it is released now.
  assign w_other_busy = r_full[~r_wr_slot] & ~(w_release & (r_rd_slot != r_wr_slot));
  assign w_start = r_full[r_oldest] &
                   ((r_state == S_IDLE) | ((r_state == S_GAP) & (r_gap_cnt == GAP_LAST)));

  // Index/slot of the byte to be loaded into the output register next.
  assign w_slot = ((r_state == S_IDLE) || (r_state == S_GAP)) ? r_oldest : r_rd_slot;
  assign w_idx  = ((r_state == S_IDLE) || (r_state == S_GAP)) ? 8'd0 : r_byte + 8'd1;

  always_comb begin
    w_off = w_idx - 8'd6;
    if (w_idx < 8'd4) begin
      w_word_idx = 6'd1;
      w_lane     = w_idx[1:0];
    end else if (w_idx < 8'd6) begin
      w_word_idx = 6'd0;
      w_lane     = {1'b1, w_idx[0]};         // port[15:8] then port[7:0]
    end else begin
      w_word_idx = 6'd2 + w_off[7:2];
      w_lane     = w_off[1:0];
    end
    w_word = r_mem[w_slot][w_word_idx];
    case (w_lane)
      2'd0:    w_byte = w_word[31:24];
      2'd1:    w_byte = w_word[23:16];
      2'd2:    w_byte = w_word[15:8];
      default: w_byte = w_word[7:0];
    endcase
  end

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_full     <= '0;
      r_oldest   <= 1'b0;
      r_rd_slot  <= 1'b0;
      r_in_burst <= 1'b0;
      r_cap_act  <= 1'b0;
      r_wr_slot  <= 1'b0;
      r_wr_cnt   <= '0;
      r_state    <= S_IDLE;
      r_byte     <= '0;
      r_gap_cnt  <= '0;
      out_data   <= '0;
      out_en     <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_gbe    <= '0;
      err_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      r_in_burst <= din_en;

      if (w_burst_start) begin
        r_cap_act <= w_slot_avail;
        r_wr_slot <= w_new_slot;
        r_wr_cnt  <= 6'd1;
        if (!w_slot_avail && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end else if (din_en && r_cap_act && r_wr_cnt != '1) begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
      end
      if (w_burst_end) r_cap_act <= 1'b0;
      if (w_reject && err_cnt != '1) err_cnt <= err_cnt + 1'b1;

      // Release and commit always touch different slots; the commit
      // assignment to r_oldest wins only when no older packet remains.
      if (w_release) begin
        r_full[r_rd_slot] <= 1'b0;
        r_oldest          <= ~r_rd_slot;
      end
      if (w_commit) begin
        r_full[r_wr_slot] <= 1'b1;
        if (!w_other_busy) r_oldest <= r_wr_slot;
      end

      case (r_state)
        S_HDR, S_BODY: begin
          if (w_accept) begin
            if (w_release) begin
              out_en    <= 1'b0;
              out_sop   <= 1'b0;
              out_eop   <= 1'b0;
              r_gap_cnt <= '0;
              r_state   <= (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
            end else begin
              r_byte   <= r_byte + 8'd1;
              out_data <= w_byte;
              out_sop  <= 1'b0;
              out_eop  <= (r_byte + 8'd1 == 8'(PKT_BYTES - 1));
              if (r_byte == 8'd5) r_state <= S_BODY;
            end
          end
        end
        default: begin // S_IDLE, S_GAP
          if (w_start) begin
            r_state   <= S_HDR;
            r_rd_slot <= r_oldest;
            r_byte    <= '0;
            out_en    <= 1'b1;
            out_sop   <= 1'b1;
            out_eop   <= 1'b0;
            out_data  <= w_byte;
            out_gbe   <= r_mem[r_oldest][0][31:30];
          end else if (r_state == S_GAP) begin
            if (r_gap_cnt == GAP_LAST) r_state <= S_IDLE;
            else                       r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_gbe_framer.sv
// Testbench for ts_gbe_framer: scoreboard of expected output bytes filled as
// bursts are driven, drained and compared by a monitor on the falling edge.

module tb_ts_gbe_framer;

  localparam int PKT_WORDS  = 49;
  localparam int IFG_CYCLES = 4;
  localparam int CNT_W      = 16;
  localparam int PKT_BYTES  = 194;

  typedef struct packed {
    logic [1:0] gbe;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      din;
  logic             din_en;
  logic [7:0]       out_data;
  logic             out_en, out_sop, out_eop;
  logic [1:0]       out_gbe;
  logic             out_rdy;
  logic [CNT_W-1:0] err_cnt, drop_cnt;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc   = 0;
  int   idle  = 0;
  bit   gap_chk  = 1'b0;
  bit   eop_seen = 1'b0;
  int   exp_err;

  ts_gbe_framer #(.PKT_WORDS(PKT_WORDS), .IFG_CYCLES(IFG_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en),
    .out_data(out_data), .out_en(out_en), .out_sop(out_sop), .out_eop(out_eop),
    .out_gbe(out_gbe), .out_rdy(out_rdy), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] g, input bit s, input bit e, input logic [7:0] d);
    exp_t x;
    x.gbe = g; x.sop = s; x.eop = e; x.data = d;
    q.push_back(x);
  endtask

  // Drives an nw-word burst; leaves din_en low in the evaluation cycle.
  task automatic send_burst(input int nw, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input bit commit);
    logic [31:0] w;
    if (commit) begin
      push(w0[31:30], 1'b1, 1'b0, w1[31:24]);
      push(w0[31:30], 1'b0, 1'b0, w1[23:16]);
      push(w0[31:30], 1'b0, 1'b0, w1[15:8]);
      push(w0[31:30], 1'b0, 1'b0, w1[7:0]);
      push(w0[31:30], 1'b0, 1'b0, w0[15:8]);
      push(w0[31:30], 1'b0, 1'b0, w0[7:0]);
    end
    for (int i = 0; i < nw; i++) begin
      tick();
      w = (i == 0) ? w0 : (i == 1) ? w1 : (i == 2) ? w2 : $urandom;
      din    = w;
      din_en = 1'b1;
      if (commit && i >= 2 && i < PKT_WORDS) begin
        push(w0[31:30], 1'b0, 1'b0, w[31:24]);
        push(w0[31:30], 1'b0, 1'b0, w[23:16]);
        push(w0[31:30], 1'b0, 1'b0, w[15:8]);
        push(w0[31:30], 1'b0, (i == PKT_WORDS - 1), w[7:0]);
      end
    end
    tick();
    din_en = 1'b0;
    din    = '0;
  endtask

  task automatic wait_drain(input int maxc);
    int c = 0;
    while (q.size() != 0 && c < maxc) begin
      tick();
      c++;
    end
    chk("drain", q.size(), 0);
  endtask

  // Monitor: every presented byte is compared with the scoreboard head, so
  // a byte held during a stall is checked on each stalled cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_en) begin
        if (q.size() == 0) begin
          chk("unexpected_out", out_en, 0);
        end else begin
          e = q[0];
          chk("byte", {20'd0, out_gbe, out_sop, out_eop, out_data},
                      {20'd0, e.gbe, e.sop, e.eop, e.data});
          if (out_rdy) begin
            void'(q.pop_front());
            acc++;
            if (out_sop && gap_chk && eop_seen) chk("ifg", idle, IFG_CYCLES);
            if (out_eop) begin
              chk("pkt_len", acc, PKT_BYTES);
              acc = 0;
              eop_seen = 1'b1;
            end
          end
        end
        idle = 0;
      end else begin
        idle++;
      end
      if (!gap_chk) eop_seen = 1'b0;
    end
  end

  initial begin
    int n;
    int c;
    rst = 1'b0; din = '0; din_en = 1'b0; out_rdy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_en", out_en, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_sop, out_eop, out_gbe}, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    tick();
    rst = 1'b1;
    tick();

    // Single packet
    out_rdy = 1'b1;
    send_burst(49, 32'h4000_1F90, 32'hC0A8_0102, 32'h4712_3456, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_en && n < 8) begin
      tick();
      n++;
      @(negedge clk);
    end
    chk("latency_in_range", (n >= 2 && n <= 3), 1);
    wait_drain(600);
    repeat (IFG_CYCLES) begin
      tick();
      @(negedge clk);
      chk("ifg_idle", out_en, 0);
    end

    // Length errors
    send_burst(48, 32'h8000_0001, 32'h0A00_0001, 32'h4700_0000, 1'b0);
    send_burst(50, 32'h8000_0002, 32'h0A00_0002, 32'h4700_0000, 1'b0);
    repeat (10) tick();
    chk("len_err_cnt", err_cnt, 2);
    chk("len_drop_cnt", drop_cnt, 0);

    // Backpressure and drop: both slots must still be free here
    out_rdy = 1'b0;
    send_burst(49, 32'h8000_1111, 32'h0102_0304, 32'h47AA_BBCC, 1'b1);
    send_burst(49, 32'hC000_2222, 32'h0506_0708, 32'h4711_2233, 1'b1);
    send_burst(49, 32'h0000_3333, 32'h090A_0B0C, 32'h4755_6677, 1'b0);
    repeat (20) tick();
    chk("drop_cnt", drop_cnt, 1);
    chk("bp_err_cnt", err_cnt, 2);
    @(negedge clk);
    chk("stall_out_en", out_en, 1);
    tick();
    gap_chk = 1'b1;
    out_rdy = 1'b1;
    wait_drain(1200);
    gap_chk = 1'b0;

    // Ready toggling
    out_rdy = 1'b0;
    send_burst(49, 32'h4000_ABCD, 32'hDEAD_BEEF, 32'h4701_0203, 1'b1);
    c = 0;
    while (q.size() != 0 && c < 1500) begin
      tick();
      out_rdy = ~out_rdy;
      c++;
    end
    chk("toggle_drain", q.size(), 0);
    out_rdy = 1'b1;
    repeat (10) tick();

    // Sync byte mismatch
`ifdef TS_SYNC_CHECK_EN
    send_burst(49, 32'h4000_0050, 32'hC0A8_0003, 32'h4800_0000, 1'b0);
    exp_err = 3;
`else
    send_burst(49, 32'h4000_0050, 32'hC0A8_0003, 32'h4800_0000, 1'b1);
    exp_err = 2;
`endif
    repeat (5) tick();
    wait_drain(600);
    repeat (10) tick();
    chk("sync_err_cnt", err_cnt, exp_err);

    // Reset mid-packet
    acc = 0;
    send_burst(49, 32'h8000_0077, 32'h1122_3344, 32'h4766_7788, 1'b1);
    c = 0;
    while (acc < 100 && c < 600) begin
      tick();
      c++;
    end
    chk("rst_reach_byte", acc, 100);
    rst = 1'b0;
    out_rdy = 1'b0;
    tick();
    rst = 1'b1;
    q.delete();
    acc = 0;
    @(negedge clk);
    chk("midrst_out_en", out_en, 0);
    chk("midrst_err", err_cnt, 0);
    chk("midrst_drop", drop_cnt, 0);
    tick();
    out_rdy = 1'b1;
    send_burst(49, 32'h4000_0099, 32'hAABB_CCDD, 32'h47EE_FF00, 1'b1);
    wait_drain(600);
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
